// File: rtl/btn_cond_pkg.sv
// Shared types and defaults for the push-button conditioner.
// The single-button guard is enabled by defining BTN_COND_SINGLE_EN.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        ST_UP       = 2'd0,
        ST_DOWN_CHK = 2'd1,
        ST_DOWN     = 2'd2,
        ST_UP_CHK   = 2'd3
    } cell_state_e;

    localparam int DEBOUNCE_DEFAULT = 1_000_000;
    localparam int N_BTN_DEFAULT    = 3;

    // A single-cycle debounce still needs a one-bit counter to exist.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: two-flop synchronizer, four-state debounce cell and registered
// active-low level plus press/release pulses. inhibit_i pins the cell in UP.
module btn_debounce_cell
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic inhibit_i,
    output logic clean_o,
    output logic press_o,
    output logic release_o,
    output logic busy_o,
    output logic enter_down_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    cell_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          enter_down;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_down = 1'b0;
        unique case (state_q)
            ST_UP: begin
                if (!sync2_q) begin
                    state_d = ST_DOWN_CHK;
                    cnt_d   = '0;
                end
            end
            ST_DOWN_CHK: begin
                if (sync2_q) begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_DOWN;
                    enter_down = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DOWN: begin
                if (sync2_q) begin
                    state_d = ST_UP_CHK;
                    cnt_d   = '0;
                end
            end
            ST_UP_CHK: begin
                if (!sync2_q) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_UP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_UP;
                cnt_d   = '0;
            end
        endcase

        // Inhibit only blocks a press in progress; an accepted press is left alone.
        if (inhibit_i && (state_q == ST_UP || state_q == ST_DOWN_CHK)) begin
            state_d = ST_UP;
            cnt_d   = '0;
        end

        clean_d   = !(state_d == ST_DOWN || state_d == ST_UP_CHK);
        press_d   = (state_q == ST_DOWN_CHK) && (state_d == ST_DOWN);
        release_d = (state_q == ST_UP_CHK) && (state_d == ST_UP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_UP;
            cnt_q     <= '0;
            clean_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign clean_o      = clean_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign busy_o       = (state_q == ST_DOWN) || (state_q == ST_UP_CHK);
    assign enter_down_o = enter_down;

endmodule

// File: rtl/btn_conditioner.sv
// Synchronizes and debounces N_BTN active-low buttons for the lock FSM.
// Define BTN_COND_SINGLE_EN to allow at most one button low on btn_clean.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_clean,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    logic [N_BTN-1:0] busy;
    logic [N_BTN-1:0] enter_down;
    logic [N_BTN-1:0] inhibit;

`ifdef BTN_COND_SINGLE_EN
    logic [N_BTN-1:0] others;
    logic             multi_enter;

    // Block any bit while another is held, and cancel simultaneous acceptances.
    always_comb begin
        inhibit     = '0;
        others      = '0;
        multi_enter = ($countones(enter_down) > 1);
        for (int i = 0; i < N_BTN; i++) begin
            others     = busy;
            others[i]  = 1'b0;
            inhibit[i] = (|others) || (multi_enter && enter_down[i]);
        end
    end
`else
    logic unused_guard;
    assign unused_guard = ^{busy, enter_down};
    assign inhibit      = '0;
`endif

    for (genvar g = 0; g < N_BTN; g++) begin : g_cell
        btn_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk_i       (clk),
            .rst_i       (rst),
            .raw_i       (btn_raw[g]),
            .inhibit_i   (inhibit[g]),
            .clean_o     (btn_clean[g]),
            .press_o     (btn_press[g]),
            .release_o   (btn_release[g]),
            .busy_o      (busy[g]),
            .enter_down_o(enter_down[g])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner (DEBOUNCE_CYCLES=4, N_BTN=3): directed scenarios
// plus random button activity against a run-length reference model.
module tb_btn_conditioner;

    localparam int N = 3;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_clean;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: raw history seen through two flops, accepted level,
    // and the number of consecutive samples disagreeing with that level.
    logic [N-1:0] h1, h2, lvl, exp_press, exp_rel;
    int           run [N];

    btn_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_clean  (btn_clean),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] raw, input logic r);
        logic [N-1:0] s, flip;
        if (r) begin
            h1 = '1; h2 = '1; lvl = '1;
            exp_press = '0; exp_rel = '0;
            for (int i = 0; i < N; i++) run[i] = 0;
        end else begin
            s = h2; h2 = h1; h1 = raw;
            exp_press = '0; exp_rel = '0; flip = '0;
            for (int i = 0; i < N; i++) begin
                run[i] = (s[i] != lvl[i]) ? run[i] + 1 : 0;
                if (run[i] == D + 1) flip[i] = 1'b1;
            end
`ifdef BTN_COND_SINGLE_EN
            for (int i = 0; i < N; i++) begin
                logic [N-1:0] oth;
                oth = ~lvl;
                oth[i] = 1'b0;
                if (lvl[i] && (|oth)) begin
                    run[i] = 0; flip[i] = 1'b0;
                end
            end
            if ($countones(flip & lvl) > 1) begin
                for (int i = 0; i < N; i++) begin
                    if (flip[i] && lvl[i]) begin
                        run[i] = 0; flip[i] = 1'b0;
                    end
                end
            end
`endif
            for (int i = 0; i < N; i++) begin
                if (flip[i]) begin
                    lvl[i] = ~lvl[i];
                    run[i] = 0;
                    if (lvl[i]) exp_rel[i] = 1'b1;
                    else        exp_press[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] raw, input logic r);
        btn_raw = raw;
        rst     = r;
        @(posedge clk);
        model_edge(raw, r);
        #1;
        chk("clean", btn_clean, lvl);
        chk("press", btn_press, exp_press);
        chk("release", btn_release, exp_rel);
        chk("press_and_release", btn_press & btn_release, '0);
    endtask

    task automatic hold(input logic [N-1:0] raw, input int cycles);
        for (int k = 0; k < cycles; k++) step(raw, 1'b0);
    endtask

    // Counts edges from the first sampling edge until bit 0 pulses press.
    task automatic latency0(input logic [N-1:0] raw, input string tag);
        int first;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            step(raw, 1'b0);
            if (btn_press[0] === 1'b1 && first == 0) first = k;
        end
        vectors++;
        assert (first == D + 3) else begin
            miscompares++;
            $error("FAIL %s got=%0d exp=%0d", tag, first, D + 3);
        end
    endtask

    initial begin
        btn_raw = '1;
        rst     = 1'b1;
        for (int i = 0; i < N; i++) run[i] = 0;
        h1 = '1; h2 = '1; lvl = '1; exp_press = '0; exp_rel = '0;

        for (int k = 0; k < 3; k++) step(3'b000, 1'b1);
        hold(3'b000, 10);
        hold(3'b111, 10);

        latency0(3'b110, "press_latency");
        hold(3'b111, 10);

        for (int k = 0; k < 16; k++) step(((k / 2) % 2 == 0) ? 3'b101 : 3'b111, 1'b0);
        hold(3'b111, 6);
        hold(3'b101, 10);
        hold(3'b111, 10);

        hold(3'b011, 10);
        hold(3'b111, 10);

        hold(3'b110, 4);
        step(3'b110, 1'b1);
        latency0(3'b110, "reset_latency");
        hold(3'b111, 10);

        hold(3'b110, 10);
        hold(3'b100, 10);
        hold(3'b111, 10);
        hold(3'b100, 10);
        hold(3'b111, 10);

        for (int seg = 0; seg < 60; seg++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(0, 7));
            hold(r, $urandom_range(1, 10));
        end
        hold(3'b111, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-conditioning stage directly upstream of the safe-cracking FSM.
- Takes the raw, asynchronous, active-low push buttons BTN[2:0], synchronizes and debounces each one, and drives a glitch-free active-low level bus that feeds the FSM's btn input.
- Also provides active-high single-cycle press and release pulses for other consumers.
- Removes contact bounce so that one physical press yields exactly one edge downstream.

Parameters:
- N_BTN, 3, number of buttons conditioned.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized samples (at clk) required to accept a level change; 20 ms at 50 MHz; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  raw buttons, active-low (0 = pressed), asynchronous to clk.
- btn_clean  output  N_BTN  debounced level, active-low, drives the FSM btn input.
- btn_press  output  N_BTN  one-cycle active-high pulse when a debounced press is accepted.
- btn_release  output  N_BTN  one-cycle active-high pulse when a debounced release is accepted.

Behaviour:
- Synchronous active-high reset, applied on the clk edge where rst=1:
  - both synchronizer flops of every bit are set to 1 (released);
  - btn_clean = all ones; btn_press = 0; btn_release = 0;
  - every cell returns to UP with its counter at 0.
- Synchronizer: two flops per bit. The raw level is visible at the sync2 output 2 edges after it changes.
- Each bit has an independent 4-state cell: UP, DOWN_CHK, DOWN, UP_CHK.
  - UP: btn_clean bit = 1. If sync2 = 0, go to DOWN_CHK and clear cnt.
  - DOWN_CHK: if sync2 = 1, return to UP and clear cnt (bounce rejected). Otherwise, if cnt == DEBOUNCE_CYCLES-1, go to DOWN; else increment cnt.
  - DOWN: btn_clean bit = 0. If sync2 = 1, go to UP_CHK and clear cnt.
  - UP_CHK: mirror of DOWN_CHK. sync2 = 0 returns to DOWN; a full stable count goes to UP.
- Outputs are registered.
  - btn_press is high for exactly the one cycle in which btn_clean first reads 0. It is set on the same edge that enters DOWN.
  - btn_release behaves the same way on entering UP.
- Latency: a clean raw transition appears on btn_clean exactly DEBOUNCE_CYCLES+3 clk edges after the first edge that samples it.
- Counter width is $clog2(DEBOUNCE_CYCLES); the counter never wraps because it is cleared on every check entry.
- Boundary conditions:
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change and no pulse.
  - Simultaneous presses on several bits are handled independently; several btn_press bits may assert together.
  - Reset asserted mid-count discards the count. Outputs read released on the next cycle, even if the button is still physically held. A held button is then re-accepted as a new press DEBOUNCE_CYCLES+3 edges after rst falls.
  - btn_press and btn_release for the same bit are never high together.

Optional Feature:
- Macro BTN_COND_SINGLE_EN.
- Defined (single-button guard):
  - While any bit is in DOWN or UP_CHK, new presses on other bits are ignored. Their cells are held in UP and cnt is cleared.
  - If two or more cells would enter DOWN on the same edge, none do. All of those cells return to UP, and no btn_press is emitted.
  - Purpose: guarantees at most one low bit on btn_clean.
- Undefined: all bits are fully independent, as described in Behaviour.

Decomposition:
- Package btn_cond_pkg:
  - typedef enum for the cell states (UP, DOWN_CHK, DOWN, UP_CHK);
  - localparam DEBOUNCE_DEFAULT = 1_000_000;
  - localparam N_BTN_DEFAULT = 3.
- Sub-module btn_debounce_cell, one per bit, containing the synchronizer, counter, state and pulse registers.
  - Extra input inhibit is driven by the top under BTN_COND_SINGLE_EN and tied to 0 otherwise.
- The top generates N_BTN cells and contains the guard logic.

Test Plan (DEBOUNCE_CYCLES=4, N_BTN=3):
- Reset: hold rst high 3 cycles with btn_raw=3'b000 -> btn_clean=3'b111, btn_press=0, btn_release=0 throughout; after release, btn_clean[all]=0 exactly 7 edges later with btn_press=3'b111 for 1 cycle (guard undefined).
- Clean press: btn_raw 111->110, held 20 cycles -> btn_clean=110 exactly 7 edges after the first sampling edge; btn_press=001 for exactly 1 cycle; no further pulses.
- Bounce rejection: btn_raw[1] toggles 0/1 every 2 cycles for 16 cycles, then stays 1 -> btn_clean stays 111 and no pulses; then held 0 for 10 cycles -> a single btn_press=010.
- Release: from held 011 (bit 2 pressed), raw returns to 111 -> btn_clean=111 after 7 edges; btn_release=100 for 1 cycle.
- Reset mid-count: raw=110, assert rst at count 2 for 1 cycle -> no press pulse before rst; btn_press=001 exactly 7 edges after rst deasserts.
- Guard (BTN_COND_SINGLE_EN): raw 110 accepted, then raw 100 -> btn_clean stays 110 and no press on bit 1; simultaneous raw 111->100 from idle -> btn_clean stays 111 and no press.
